fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Instruction-fetch front end; consumes the execute stage's pc_sel/branch target.
//   Holds the PC, issues word requests to instruction memory, buffers responses in a
//   2-entry FIFO, and presents {pc, instr} to decode over valid/ready.
//   On redirect: flushes buffered and in-flight fetches, restarts at the target.
// PARAMETERS
//   RESET_PC   32'h0100_0000   first fetch address after reset
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst_n          in   1   asynchronous reset, active low
//   pc_sel         in   1   execute-stage redirect request (JAL/JALR/taken branch)
//   redirect_pc    in   32  redirect target (ALU result)
//   imem_req_valid out  1   fetch request valid
//   imem_req_ready in   1   memory accepts request
//   imem_addr      out  32  word-aligned fetch address
//   imem_rsp_valid in   1   response valid, 1+ cycles after accept; cannot be stalled
//   imem_rsp_data  in   32  fetched instruction word
//   if_valid       out  1   {if_pc, if_instr} valid to decode
//   if_ready       in   1   decode accepts (low = stall)
//   if_pc          out  32  PC of presented instruction
//   if_instr       out  32  presented instruction
//   if_misaligned  out  1   sticky misaligned-target flag (IF_MISALIGN_CHECK_EN only)
// BEHAVIOUR
//   Reset (async, rst_n=0): pc_q=RESET_PC; FIFO empty; outstanding=0; discard=0;
//     if_valid=0; imem_req_valid=0; if_pc=0; if_instr=0; if_misaligned=0.
//   States: ISSUE (may request), WAIT (1 request outstanding, max 1 at any time).
//   Credit: imem_req_valid = (state==ISSUE) & (fifo_count + outstanding < 2) & ~pc_sel.
//   ISSUE: imem_addr=pc_q. Handshake valid&ready -> WAIT; issued_pc<=pc_q;
//     pc_q<=pc_q+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
//   WAIT: on imem_rsp_valid -> ISSUE. If discard=1, drop the word and clear discard;
//     else push {issued_pc, imem_rsp_data} into the FIFO.
//   FIFO: 2 entries; head drives if_pc/if_instr; if_valid = count!=0; pop on
//     if_valid&if_ready. Push and pop in the same cycle are legal, incl. when full.
//   Decode latency: response pushed at edge N -> if_valid high after edge N when
//     FIFO was empty (registered, no combinational mem->decode path).
//   Redirect (pc_sel=1 at edge): highest priority over all other events.
//     - pc_q <= {redirect_pc[31:2],2'b00}; FIFO cleared (if_valid=0 next cycle).
//     - imem_req_valid forced low this cycle; no request is issued.
//     - WAIT without same-cycle response: discard<=1, stay WAIT.
//     - Same-cycle response: dropped, discard stays 0, -> ISSUE.
//     - Same-cycle pop by decode: ignored; the entry is flushed anyway.
//     - Back-to-back redirects: the last one wins; discard never counts above 1.
//   Empty FIFO + if_ready: no pop, no underflow. Full FIFO: no requests issued.
//   rst_n assertion mid-request: state cleared at once; a late memory response
//     after release is ignored (state ISSUE, not WAIT).
// CONFIGURATION
//   IF_MISALIGN_CHECK_EN defined:
//     - Redirect with redirect_pc[1:0]!=0 sets if_misaligned=1.
//     - Fetching stops (imem_req_valid=0) until an aligned redirect clears the flag.
//   Not defined: low address bits silently zeroed; if_misaligned tied to 0.
// TESTING
//   Reset release, memory always ready, 1-cycle rsp, if_ready=1 -> if_pc sequence
//     0x01000000, 0x01000004, 0x01000008...; at most 1 request outstanding.
//   if_ready=0 for 10 cycles -> FIFO fills to 2; imem_req_valid=0; entries held.
//     Release -> words delivered in order, none lost or duplicated.
//   pc_sel=1, redirect_pc=0x200 while in WAIT; rsp 3 cycles later ->
//     that word dropped; next if_pc=0x200.
//   pc_sel=1 coincident with imem_rsp_valid and with a full FIFO ->
//     if_valid=0 next cycle; next fetch 0x200; no stale instruction reaches decode.
//   PC at 0xFFFFFFFC -> next request addresses 0x00000000.
//   IF_MISALIGN_CHECK_EN: redirect_pc=0x202 -> if_misaligned=1, no requests.
//     Redirect 0x300 -> flag clears, fetch resumes at 0x300. Undefined: fetch at 0x200.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem requests, 2-entry response FIFO.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky flag and halt fetch.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_sel,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misaligned
);

    typedef enum logic {S_ISSUE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_issued_pc;
    logic        r_discard;
    logic [31:0] r_fifo_pc    [2];
    logic [31:0] r_fifo_instr [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_outstanding;
    logic        w_credit;
    logic        w_hold;
    logic        w_req_fire;
    logic        w_rsp_take;
    logic        w_push;
    logic        w_pop;

    assign w_outstanding = (r_state == S_WAIT);
    assign w_credit      = (({1'b0, r_count} + {2'b00, w_outstanding}) < 3'd2);
    assign w_req_fire    = imem_req_valid & imem_req_ready;
    assign w_rsp_take    = (r_state == S_WAIT) & imem_rsp_valid;
    assign w_push        = w_rsp_take & ~r_discard & ~pc_sel;
    assign w_pop         = (r_count != 2'd0) & if_ready & ~pc_sel;

`ifdef IF_MISALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (pc_sel) begin
            r_misaligned <= |redirect_pc[1:0];
        end
    end

    assign w_hold        = r_misaligned;
    assign if_misaligned = r_misaligned;
`else
    logic w_unused_lo;

    assign w_unused_lo   = ^redirect_pc[1:0];
    assign w_hold        = 1'b0;
    assign if_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect never leaves WAIT on its own: the in-flight word still has to come back.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ISSUE: if (w_req_fire)     w_state_nxt = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) w_state_nxt = S_ISSUE;
            default: w_state_nxt = S_ISSUE;
        endcase
    end

    // rst_n gates the request so nothing is offered to memory while reset is held.
    always_comb begin
        imem_req_valid = rst_n & (r_state == S_ISSUE) & w_credit & ~pc_sel & ~w_hold;
        imem_addr      = r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_issued_pc <= 32'd0;
        end else if (pc_sel) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_req_fire) begin
            r_pc        <= r_pc + 32'd4;
            r_issued_pc <= r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_discard <= 1'b0;
        end else if (pc_sel) begin
            r_discard <= (r_state == S_WAIT) & ~imem_rsp_valid;
        end else if (w_rsp_take) begin
            r_discard <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= 32'd0;
                r_fifo_instr[i] <= 32'd0;
            end
        end else if (pc_sel) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_issued_pc;
                r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign if_valid = (r_count != 2'd0);
    assign if_pc    = r_fifo_pc[r_rd_ptr];
    assign if_instr = r_fifo_instr[r_rd_ptr];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: behavioural imem with configurable latency, scoreboard of expected PCs.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_misaligned(if_misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] target;
        int          lat;
        int          pct;
        int          nwords;
        logic [31:0] exp_first;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: one slot, response m_lat cycles after the accepting edge.
    int          m_lat = 1;
    int          m_wait = 0;
    logic        m_busy = 1'b0;
    logic        m_overlap = 1'b0;
    logic        m_acc;
    logic [31:0] m_a;
    logic [31:0] m_addr = 32'd0;

    always @(posedge clk) begin
        m_acc = rst_n & imem_req_valid & imem_req_ready;
        m_a   = imem_addr;
        #1;
        imem_rsp_valid = 1'b0;
        if (m_busy) begin
            m_wait--;
            if (m_wait <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(m_addr);
                m_busy         = 1'b0;
            end
        end
        if (m_acc) begin
            if (m_busy) m_overlap = 1'b1;
            m_busy = 1'b1;
            m_addr = m_a;
            m_wait = m_lat - 1;
            if (m_wait <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(m_addr);
                m_busy         = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] first, input int n);
        logic [31:0] p;
        p = first;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    // Called just after a negedge; returns at the following negedge with pc_sel low.
    task automatic redirect(input logic [31:0] t, input logic [31:0] first, input int n);
        pc_sel      = 1'b1;
        redirect_pc = t;
        if_ready    = 1'b1;
        #1;
        check("req_blocked_on_redirect", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        pc_sel   = 1'b0;
        if_ready = 1'b0;
        check("flush_valid", 32'(if_valid), 32'd0);
        exp_q.delete();
        fill(first, n);
    endtask

    task automatic run_words(input int n, input int pct, input int budget);
        int          got;
        int          cyc;
        logic [31:0] e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%h expected=none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_instr", if_instr, mem_word(e));
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        if_ready = 1'b0;
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL delivery_timeout actual=%0d expected=%0d", got, n);
        end
    endtask

    task automatic wait_accept();
        int c;
        c = 0;
        while (!(imem_req_valid && imem_req_ready) && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("accept_seen", 32'(imem_req_valid & imem_req_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[5];
        int   c;
        vecs[0] = '{32'h0000_2000, 1, 100, 6, 32'h0000_2000};
        vecs[1] = '{32'h0000_3000, 2,  60, 6, 32'h0000_3000};
        vecs[2] = '{32'h0000_4004, 3,  30, 5, 32'h0000_4004};
        vecs[3] = '{32'hFFFF_FFF8, 1, 100, 4, 32'hFFFF_FFF8};
        vecs[4] = '{32'h8000_0010, 5,  80, 4, 32'h8000_0010};

        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_misaligned", 32'(if_misaligned), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);

        fill(RESET_PC, 8);
        rst_n = 1'b1;
        run_words(8, 100, 200);

        // Decode stall: FIFO fills, requests stop, head held.
        redirect(32'h0000_1000, 32'h0000_1000, 16);
        run_words(3, 100, 100);
        repeat (10) @(negedge clk);
        check("stall_valid", 32'(if_valid), 32'd1);
        check("stall_req", 32'(imem_req_valid), 32'd0);
        check("stall_pc", if_pc, exp_q[0]);
        check("stall_instr", if_instr, mem_word(exp_q[0]));
        run_words(8, 100, 100);

        // Redirect with a full FIFO.
        repeat (6) @(negedge clk);
        check("full_req", 32'(imem_req_valid), 32'd0);
        redirect(32'h0000_0200, 32'h0000_0200, 4);
        run_words(4, 100, 100);

        for (int i = 0; i < 5; i++) begin
            m_lat = vecs[i].lat;
            redirect(vecs[i].target, vecs[i].exp_first, vecs[i].nwords);
            run_words(vecs[i].nwords, vecs[i].pct, 100 + vecs[i].nwords * vecs[i].lat * 8);
        end

        // Redirect while WAIT; stale word returns 3 cycles later.
        m_lat = 4;
        redirect(32'h0000_0A00, 32'h0000_0A00, 0);
        wait_accept();
        redirect(32'h0000_0200, 32'h0000_0200, 4);
        run_words(4, 100, 100);

        // Back-to-back redirects in WAIT: last target wins.
        m_lat = 3;
        redirect(32'h0000_0B00, 32'h0000_0B00, 0);
        wait_accept();
        pc_sel      = 1'b1;
        redirect_pc = 32'h0000_0400;
        @(negedge clk);
        redirect(32'h0000_0500, 32'h0000_0500, 4);
        run_words(4, 100, 100);

        // Redirect coincident with a response.
        m_lat = 3;
        redirect(32'h0000_0800, 32'h0000_0800, 0);
        c = 0;
        while (!(imem_rsp_valid && if_valid) && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("coinc_seen", 32'(imem_rsp_valid & if_valid), 32'd1);
        redirect(32'h0000_0200, 32'h0000_0200, 4);
        run_words(4, 100, 100);

        // Reset while a request is outstanding; late response must be ignored.
        m_lat = 4;
        redirect(32'h0000_0C00, 32'h0000_0C00, 0);
        wait_accept();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check("midrst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("late_rsp_ignored", 32'(if_valid), 32'd0);
        check("post_rst_issue", 32'(imem_req_valid), 32'd1);
        exp_q.delete();
        fill(RESET_PC, 4);
        imem_req_ready = 1'b1;
        run_words(4, 100, 100);

        m_lat = 1;
`ifdef IF_MISALIGN_CHECK_EN
        redirect(32'h0000_0202, 32'h0000_0200, 0);
        check("mis_set", 32'(if_misaligned), 32'd1);
        repeat (5) @(negedge clk);
        check("mis_no_req", 32'(imem_req_valid), 32'd0);
        check("mis_no_valid", 32'(if_valid), 32'd0);
        redirect(32'h0000_0300, 32'h0000_0300, 4);
        check("mis_clear", 32'(if_misaligned), 32'd0);
        run_words(4, 100, 100);
`else
        redirect(32'h0000_0202, 32'h0000_0200, 4);
        check("mis_tied_low", 32'(if_misaligned), 32'd0);
        run_words(4, 100, 100);
`endif

        check("single_outstanding", 32'(m_overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
